// File: rtl/bist_controller.sv
// bist_controller
//   On-chip BIST engine sitting between the chip pins and the circuit under
//   test (CUT). In functional mode the pins pass straight through; in BIST
//   mode an LFSR drives the CUT and a MISR compacts its outputs. At the end of
//   the run the signature is compared against GOLDEN_SIG.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   bistmode   1 = run BIST, 0 = functional mode
//   pi         functional primary inputs
//   cut_pi     CUT inputs: pi while IDLE, LFSR value otherwise
//   cut_po     CUT outputs, compacted into the MISR
//   bistdone   run complete, held high in DONE
//   bistpass   signature matched GOLDEN_SIG (valid while bistdone=1)
//   signature  current MISR contents (debug)
module bist_controller #(
  parameter int                   PI_WIDTH     = 35,
  parameter int                   PO_WIDTH     = 49,
  parameter int                   NUM_PATTERNS = 2000,
  parameter int                   CUT_LATENCY  = 0,
  parameter logic [PI_WIDTH-1:0]  LFSR_SEED    = 35'h0_0000_0001,
  parameter logic [PI_WIDTH-1:0]  LFSR_POLY    = 35'h5_0000_0000,
  parameter logic [PO_WIDTH-1:0]  MISR_POLY    = 49'h0_0200_0000_0001,
  parameter logic [PO_WIDTH-1:0]  GOLDEN_SIG   = 49'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bistmode,
  input  logic [PI_WIDTH-1:0] pi,
  output logic [PI_WIDTH-1:0] cut_pi,
  input  logic [PO_WIDTH-1:0] cut_po,
  output logic                bistdone,
  output logic                bistpass,
  output logic [PO_WIDTH-1:0] signature
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] CMP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Counter spans the whole RUN phase (patterns plus latency tail) without wrapping.
  localparam int CNT_W = $clog2(NUM_PATTERNS + CUT_LATENCY + 1);
  localparam logic [CNT_W-1:0] NUM_PAT_C  = CNT_W'(NUM_PATTERNS);
  localparam logic [CNT_W-1:0] RUN_LAST_C = CNT_W'(NUM_PATTERNS + CUT_LATENCY - 1);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [PI_WIDTH-1:0] SEED = (LFSR_SEED == '0) ? PI_WIDTH'(1) : LFSR_SEED;

  logic [1:0]           state;
  logic [PI_WIDTH-1:0]  lfsr;
  logic [PI_WIDTH-1:0]  lfsr_next;
  logic [PO_WIDTH-1:0]  misr;
  logic [PO_WIDTH-1:0]  misr_next;
  logic [CNT_W-1:0]     cnt;
  logic                 vld_in;
  logic [CUT_LATENCY:0] vld_pipe;

  assign cut_pi    = (state == IDLE) ? pi : lfsr;
  assign signature = misr;

  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
  assign misr_next = ((misr << 1) ^ (misr[PO_WIDTH-1] ? MISR_POLY : '0)) ^ cut_po;

  // A pattern is "issued" in each of the first NUM_PATTERNS RUN cycles; its
  // response reaches the MISR CUT_LATENCY cycles later. The latency tail issues
  // nothing, so exactly NUM_PATTERNS captures happen per run.
  assign vld_in = (state == RUN) && (cnt < NUM_PAT_C);

  generate
    if (CUT_LATENCY == 0) begin : g_no_lat
      assign vld_pipe = vld_in;
    end else begin : g_lat
      logic [CUT_LATENCY-1:0] vld_q;
      assign vld_pipe = {vld_q, vld_in};
      // Flushed outside RUN so an aborted run cannot leak captures into the next one.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                vld_q <= '0;
        else if (state != RUN)  vld_q <= '0;
        else                    vld_q <= vld_pipe[CUT_LATENCY-1:0];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lfsr     <= SEED;
      misr     <= '0;
      cnt      <= '0;
      bistdone <= 1'b0;
      bistpass <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bistmode) begin
            state <= RUN;
            lfsr  <= SEED;
            misr  <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (!bistmode) begin
            state <= IDLE;
          end else begin
            lfsr <= lfsr_next;
            cnt  <= cnt + 1'b1;
            if (vld_pipe[CUT_LATENCY]) misr <= misr_next;
            if (cnt == RUN_LAST_C)     state <= CMP;
          end
        end
        CMP: begin
          if (!bistmode) begin
            state <= IDLE;
          end else begin
            bistpass <= (misr == GOLDEN_SIG);
            bistdone <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          // DONE: everything frozen until bistmode drops.
          if (!bistmode) begin
            state    <= IDLE;
            bistdone <= 1'b0;
            bistpass <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
